id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; clk is sampled on the rising edge and rst is honoured only at that edge.
REQ-002 Ports (name, direction, width, meaning), in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold the stage contents.
- flush  in  1  insert a bubble.
- id_valid  in  1  decode stage holds a real instruction.
- id_pc  in  32  instruction PC.
- id_rd1, id_rd2  in  32  register-file read data.
- id_imm  in  32  extended immediate.
- id_rs1, id_rs2  in  5  source register indices.
- id_wr  in  5  destination register index.
- id_alu_op  in  3  ALU opcode: AND, OR, ADD, SUB, XOR, SLL, SRL, SRA.
- id_alub_sel  in  1  0 selects rd2, 1 selects imm.
- id_rf_we, id_ram_we  in  1  register-file and data-RAM write enables.
- id_wd_sel  in  2  writeback source; 2'b01 = load.
- mem_rf_we, mem_wr, mem_wd  in  1/5/32  EX/MEM write-back forwarding source.
- wb_rf_we, wb_wr, wb_wd  in  1/5/32  MEM/WB write-back forwarding source.
- ex_valid, ex_pc, ex_imm, ex_wr, ex_rf_we, ex_ram_we, ex_wd_sel  out  registered copies of the id_* fields.
- ex_alu_op  out  3  ALU opcode.
- ex_alu_a, ex_alu_b  out  32  ALU operands.
- ex_store_data  out  32  forwarded rs2 value.
- load_use  out  1  load-use hazard request to the stall logic.

Function
REQ-003 All ex_* fields SHALL be registers updated at the rising edge; the stage latency SHALL be exactly one cycle.
REQ-004 Update priority at each edge SHALL be rst > flush > stall > load.
- Load: capture all id_* fields.
- Stall: hold every register unchanged.
- Flush: write a bubble.
REQ-005 A bubble SHALL set ex_valid=0, ex_rf_we=0, ex_ram_we=0 and every other registered field to 0; flush asserted together with stall SHALL produce a bubble.
REQ-006 A load with id_valid=0 SHALL be captured as a bubble.
REQ-007 Operand A SHALL be the forwarded rs1 value (fwd1).
REQ-008 Operand B SHALL be ex_imm when the registered alub_sel=1; otherwise it SHALL be the forwarded rs2 value (fwd2).
REQ-009 ex_store_data SHALL always equal fwd2, independent of alub_sel.
REQ-010 Forwarding for source s (rs1 or rs2) SHALL be combinational from the registered index and data:
- Use mem_wd if mem_rf_we=1, mem_wr=s and s!=0.
- Otherwise use wb_wd if wb_rf_we=1, wb_wr=s and s!=0.
- Otherwise use the registered rd value.
REQ-011 When MEM and WB both match the same source, MEM SHALL take priority; register x0 SHALL never be forwarded.
REQ-012 load_use SHALL be asserted combinationally when all of the following hold:
- ex_valid=1, ex_rf_we=1 and ex_wd_sel=2'b01;
- ex_wr!=0;
- ex_wr equals id_rs1 or id_rs2;
- id_valid=1.
REQ-013 ex_alu_op SHALL pass through unmodified; opcode decoding is the ALU's job.

Reset
REQ-014 At a rising edge with rst=1, every registered output SHALL become 0 (ex_valid=0), regardless of stall or flush.
REQ-015 Reset SHALL discard any in-flight instruction; load_use SHALL read 0 during the first cycle after reset.

Configuration
REQ-016 Forwarding SHALL be included only when the macro ID_EX_FWD_EN is defined.
- Defined: forwarding behaves as in REQ-010 and REQ-011.
- Undefined: fwd1 and fwd2 SHALL equal the registered rd1 and rd2, and the mem_*/wb_* inputs SHALL be ignored.
- In both cases load_use SHALL behave as in REQ-012.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load/bypass: id_rd1=5, id_imm=7, alub_sel=1, op=ADD, id_valid=1 -> next cycle ex_alu_a=5, ex_alu_b=7, ex_valid=1.
- Stall/flush priority: stall=1 for 3 cycles with id_* changing -> outputs stay unchanged; then flush=1 with stall=1 -> ex_valid=0, ex_rf_we=0, ex_ram_we=0.
- Forward priority (ID_EX_FWD_EN): registered rs1=3, mem_wr=3/mem_wd=0xAA, wb_wr=3/wb_wd=0xBB -> ex_alu_a=0xAA; with mem_rf_we=0 -> 0xBB.
- x0 guard: rs2=0 and mem_wr=0 with mem_rf_we=1 -> ex_store_data equals the registered rd2.
- Load-use: registered load to x5 (wd_sel=01), id_rs2=5, id_valid=1 -> load_use=1; with id_rs2=6 -> 0.
- Reset mid-operation: rst=1 with stall=1 and valid contents -> next cycle all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_stage                                                |
// | Description : ID/EX pipeline register with operand forwarding from the   |
// |               MEM and WB stages and load-use hazard detection.           |
// |               Forwarding is built only when ID_EX_FWD_EN is defined;     |
// |               otherwise operands come straight from the registered       |
// |               register-file data.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_wr,
  input  logic [2:0]  id_alu_op,
  input  logic        id_alub_sel,
  input  logic        id_rf_we,
  input  logic        id_ram_we,
  input  logic [1:0]  id_wd_sel,
  input  logic        mem_rf_we,
  input  logic [4:0]  mem_wr,
  input  logic [31:0] mem_wd,
  input  logic        wb_rf_we,
  input  logic [4:0]  wb_wr,
  input  logic [31:0] wb_wd,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_wr,
  output logic        ex_rf_we,
  output logic        ex_ram_we,
  output logic [1:0]  ex_wd_sel,
  output logic [2:0]  ex_alu_op,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [31:0] ex_store_data,
  output logic        load_use
);

  // Writeback-source code that marks a load (result only known after MEM).
  localparam logic [1:0] WD_SEL_LOAD = 2'b01;
  // Architectural zero register: never a forwarding or hazard target.
  localparam logic [4:0] REG_ZERO    = 5'd0;

  logic        valid_q,    valid_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] rd1_q,      rd1_d;
  logic [31:0] rd2_q,      rd2_d;
  logic [31:0] imm_q,      imm_d;
  logic [4:0]  rs1_q,      rs1_d;
  logic [4:0]  rs2_q,      rs2_d;
  logic [4:0]  wr_q,       wr_d;
  logic [2:0]  alu_op_q,   alu_op_d;
  logic        alub_sel_q, alub_sel_d;
  logic        rf_we_q,    rf_we_d;
  logic        ram_we_q,   ram_we_d;
  logic [1:0]  wd_sel_q,   wd_sel_d;

  logic [31:0] fwd1;
  logic [31:0] fwd2;

  // Next-state select: flush wins over stall, stall holds, an invalid load is a bubble.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    wr_d       = wr_q;
    alu_op_d   = alu_op_q;
    alub_sel_d = alub_sel_q;
    rf_we_d    = rf_we_q;
    ram_we_d   = ram_we_q;
    wd_sel_d   = wd_sel_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d    = 1'b0;
      pc_d       = 32'd0;
      rd1_d      = 32'd0;
      rd2_d      = 32'd0;
      imm_d      = 32'd0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      wr_d       = 5'd0;
      alu_op_d   = 3'd0;
      alub_sel_d = 1'b0;
      rf_we_d    = 1'b0;
      ram_we_d   = 1'b0;
      wd_sel_d   = 2'd0;
    end else if (!stall) begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      rd1_d      = id_rd1;
      rd2_d      = id_rd2;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      wr_d       = id_wr;
      alu_op_d   = id_alu_op;
      alub_sel_d = id_alub_sel;
      rf_we_d    = id_rf_we;
      ram_we_d   = id_ram_we;
      wd_sel_d   = id_wd_sel;
    end
  end

  // Pipeline register; reset clears everything regardless of stall/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      rd1_q      <= 32'd0;
      rd2_q      <= 32'd0;
      imm_q      <= 32'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      wr_q       <= 5'd0;
      alu_op_q   <= 3'd0;
      alub_sel_q <= 1'b0;
      rf_we_q    <= 1'b0;
      ram_we_q   <= 1'b0;
      wd_sel_q   <= 2'd0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      wr_q       <= wr_d;
      alu_op_q   <= alu_op_d;
      alub_sel_q <= alub_sel_d;
      rf_we_q    <= rf_we_d;
      ram_we_q   <= ram_we_d;
      wd_sel_q   <= wd_sel_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // Operand bypass: the younger MEM result beats WB; x0 is never bypassed.
  always_comb begin
    fwd1 = rd1_q;
    fwd2 = rd2_q;
    if (mem_rf_we && (mem_wr == rs1_q) && (rs1_q != REG_ZERO)) begin
      fwd1 = mem_wd;
    end else if (wb_rf_we && (wb_wr == rs1_q) && (rs1_q != REG_ZERO)) begin
      fwd1 = wb_wd;
    end
    if (mem_rf_we && (mem_wr == rs2_q) && (rs2_q != REG_ZERO)) begin
      fwd2 = mem_wd;
    end else if (wb_rf_we && (wb_wr == rs2_q) && (rs2_q != REG_ZERO)) begin
      fwd2 = wb_wd;
    end
  end
`else
  // Without bypassing, operands are the values read in decode.
  always_comb begin
    fwd1 = rd1_q;
    fwd2 = rd2_q;
  end

  // Bypass sources and registered indices have no consumer in this build.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_rf_we, mem_wr, mem_wd, wb_rf_we, wb_wr, wb_wd,
                               rs1_q, rs2_q};
`endif

  // Load-use: the instruction in EX is a load whose target decode wants now.
  always_comb begin
    load_use = valid_q && rf_we_q && (wd_sel_q == WD_SEL_LOAD) &&
               (wr_q != REG_ZERO) &&
               ((wr_q == id_rs1) || (wr_q == id_rs2)) && id_valid;
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_wr         = wr_q;
  assign ex_rf_we      = rf_we_q;
  assign ex_ram_we     = ram_we_q;
  assign ex_wd_sel     = wd_sel_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_alu_a      = fwd1;
  assign ex_alu_b      = alub_sel_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                             |
// | Description : Scoreboard bench for id_ex_stage. Expected register state  |
// |               is queued when stimulus is applied and checked one edge    |
// |               later; combinational outputs are derived from that state.  |
// |               Define ID_EX_FWD_EN for both files to check bypassing.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic        clk;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_wr;
  logic [2:0]  id_alu_op;
  logic        id_alub_sel, id_rf_we, id_ram_we;
  logic [1:0]  id_wd_sel;
  logic        mem_rf_we, wb_rf_we;
  logic [4:0]  mem_wr, wb_wr;
  logic [31:0] mem_wd, wb_wd;
  logic        ex_valid, ex_rf_we, ex_ram_we, load_use;
  logic [31:0] ex_pc, ex_imm, ex_alu_a, ex_alu_b, ex_store_data;
  logic [4:0]  ex_wr;
  logic [1:0]  ex_wd_sel;
  logic [2:0]  ex_alu_op;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  wr;
    logic [2:0]  alu_op;
    logic        alub_sel;
    logic        rf_we;
    logic        ram_we;
    logic [1:0]  wd_sel;
  } st_t;

  st_t m;
  st_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_wr(id_wr),
    .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel), .id_rf_we(id_rf_we),
    .id_ram_we(id_ram_we), .id_wd_sel(id_wd_sel),
    .mem_rf_we(mem_rf_we), .mem_wr(mem_wr), .mem_wd(mem_wd),
    .wb_rf_we(wb_rf_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_wr(ex_wr),
    .ex_rf_we(ex_rf_we), .ex_ram_we(ex_ram_we), .ex_wd_sel(ex_wd_sel),
    .ex_alu_op(ex_alu_op), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .load_use(load_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference bypass: MEM before WB, x0 never bypassed.
  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rd);
    if (s == 5'd0) return rd;
`ifdef ID_EX_FWD_EN
    if (mem_rf_we && mem_wr == s) return mem_wd;
    if (wb_rf_we && wb_wr == s) return wb_wd;
`endif
    return rd;
  endfunction

  task automatic compare(input string tag, input st_t e);
    logic [31:0] f1, f2;
    logic        lu;
    f1 = fwd(e.rs1, e.rd1);
    f2 = fwd(e.rs2, e.rd2);
    lu = e.valid && e.rf_we && (e.wd_sel == 2'b01) && (e.wr != 5'd0) &&
         ((e.wr == id_rs1) || (e.wr == id_rs2)) && id_valid;
    check({tag, ".valid"},  32'(ex_valid),  32'(e.valid));
    check({tag, ".pc"},     ex_pc,          e.pc);
    check({tag, ".imm"},    ex_imm,         e.imm);
    check({tag, ".wr"},     32'(ex_wr),     32'(e.wr));
    check({tag, ".rf_we"},  32'(ex_rf_we),  32'(e.rf_we));
    check({tag, ".ram_we"}, 32'(ex_ram_we), 32'(e.ram_we));
    check({tag, ".wd_sel"}, 32'(ex_wd_sel), 32'(e.wd_sel));
    check({tag, ".alu_op"}, 32'(ex_alu_op), 32'(e.alu_op));
    check({tag, ".alu_a"},  ex_alu_a,       f1);
    check({tag, ".alu_b"},  ex_alu_b,       e.alub_sel ? e.imm : f2);
    check({tag, ".store"},  ex_store_data,  f2);
    check({tag, ".lu"},     32'(load_use),  32'(lu));
  endtask

  // Predict the next register state, queue it, clock once, then check.
  task automatic step(input string tag);
    st_t n;
    st_t e;
    n = '0;
    if (rst || flush) n = '0;
    else if (stall) n = m;
    else if (id_valid) begin
      n.valid = 1'b1;        n.pc = id_pc;            n.rd1 = id_rd1;
      n.rd2 = id_rd2;        n.imm = id_imm;          n.rs1 = id_rs1;
      n.rs2 = id_rs2;        n.wr = id_wr;            n.alu_op = id_alu_op;
      n.alub_sel = id_alub_sel; n.rf_we = id_rf_we;   n.ram_we = id_ram_we;
      n.wd_sel = id_wd_sel;
    end
    sb_q.push_back(n);
    m = n;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare(tag, e);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] wr,
                        input logic [2:0] op, input logic sel, input logic rfwe,
                        input logic ramwe, input logic [1:0] wds);
    id_valid = v;   id_pc = pc;   id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
    id_rs1 = rs1;   id_rs2 = rs2; id_wr = wr;   id_alu_op = op;
    id_alub_sel = sel; id_rf_we = rfwe; id_ram_we = ramwe; id_wd_sel = wds;
  endtask

  task automatic rand_id();
    set_id(($urandom % 4) != 0, $urandom, $urandom, $urandom, $urandom,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
  endtask

  initial begin
    m = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_rf_we = 1'b0; mem_wr = 5'd0; mem_wd = 32'd0;
    wb_rf_we  = 1'b0; wb_wr  = 5'd0; wb_wd  = 32'd0;

    step("reset");
    rst = 1'b0;
    step("idle");

    // Basic capture with immediate operand B
    set_id(1, 32'h100, 32'd5, 32'h9, 32'd7, 5'd1, 5'd2, 5'd4, OP_ADD, 1, 1, 0, 2'b00);
    step("load");

    // Stall holds while decode keeps changing
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step("stall");
    end
    flush = 1'b1;
    step("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // Invalid instruction is captured as a bubble
    set_id(0, 32'h150, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, OP_ADD, 0, 1, 1, 2'b01);
    step("invalid");

    // Bypass priority on rs1
    set_id(1, 32'h200, 32'h11, 32'h22, 32'h33, 5'd3, 5'd4, 5'd6, OP_SUB, 0, 1, 0, 2'b00);
    mem_rf_we = 1'b1; mem_wr = 5'd3; mem_wd = 32'hAA;
    wb_rf_we  = 1'b1; wb_wr  = 5'd3; wb_wd  = 32'hBB;
    step("fwd_mem");
    mem_rf_we = 1'b0; #1; compare("fwd_wb", m);
    wb_rf_we  = 1'b0; #1; compare("fwd_none", m);

    // x0 must not be bypassed; store data is fwd2 even with imm selected
    set_id(1, 32'h300, 32'h44, 32'h1234, 32'h55, 5'd0, 5'd0, 5'd8, OP_XOR, 0, 1, 1, 2'b00);
    mem_rf_we = 1'b1; mem_wr = 5'd0; mem_wd = 32'hDEAD;
    wb_rf_we  = 1'b1; wb_wr  = 5'd0; wb_wd  = 32'hBEEF;
    step("x0_guard");
    set_id(1, 32'h304, 32'h66, 32'h77, 32'h88, 5'd9, 5'd7, 5'd8, OP_ADD, 1, 0, 1, 2'b00);
    mem_wr = 5'd9; wb_wr = 5'd7;
    step("fwd_rs2");
    mem_rf_we = 1'b0; wb_rf_we = 1'b0;

    // Load-use detection
    set_id(1, 32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd5, OP_ADD, 1, 1, 0, 2'b01);
    step("ld");
    id_rs1 = 5'd0; id_rs2 = 5'd5; id_valid = 1'b1; #1; compare("lu_hit", m);
    id_rs2 = 5'd6; #1; compare("lu_miss", m);
    id_rs1 = 5'd5; #1; compare("lu_rs1", m);
    id_valid = 1'b0; #1; compare("lu_novalid", m);
    set_id(1, 32'h404, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0, 5'd0, OP_ADD, 1, 1, 0, 2'b01);
    step("ld_x0");
    id_rs1 = 5'd0; #1; compare("lu_x0", m);

    // Random mix of stall, flush, bypass and hazards
    for (int i = 0; i < 60; i++) begin
      rand_id();
      stall     = ($urandom % 4) == 0;
      flush     = ($urandom % 7) == 0;
      mem_rf_we = 1'($urandom); mem_wr = 5'($urandom_range(0, 3)); mem_wd = $urandom;
      wb_rf_we  = 1'($urandom); wb_wr  = 5'($urandom_range(0, 3)); wb_wd  = $urandom;
      step("rand");
    end
    stall = 1'b0; flush = 1'b0;

    // Reset in the middle of a stalled, valid instruction
    set_id(1, 32'h500, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, OP_ADD, 0, 1, 1, 2'b01);
    step("pre_rst");
    stall = 1'b1; rst = 1'b1; id_rs1 = 5'd3;
    step("rst_mid");
    rst = 1'b0; stall = 1'b0;
    step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
